// File: rtl/link_bringup_pkg.sv
// -----------------------------------------------------------------------------
// link_bringup_pkg
// Shared types for the PCIe link bring-up sequencer.
//   state_t         : sequencer state encoding, also driven out on seq_state
//   perst_asserted  : tells whether PERST# is held low in a given state
// -----------------------------------------------------------------------------
package link_bringup_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PERST     = 3'd1,
        ST_LINK_WAIT = 3'd2,
        ST_CONFIG    = 3'd3,
        ST_READY     = 3'd4,
        ST_BACKOFF   = 3'd5,
        ST_FAIL      = 3'd6
    } state_t;

    // The endpoint is kept in reset while waiting for a card, while the
    // reset pulse is being timed, and during the retry back-off.
    function automatic logic perst_asserted(input state_t s);
        logic v;
        case (s)
            ST_IDLE, ST_PERST, ST_BACKOFF: v = 1'b1;
            default:                       v = 1'b0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/cprsnt_debounce.sv
// -----------------------------------------------------------------------------
// cprsnt_debounce
// Brings the asynchronous, active-low card-present pin into the clock domain
// through a two-flop synchroniser and accepts a new level only after it has
// been seen on DEBOUNCE_CYCLES consecutive clocks.
// Ports:
//   i_clk        clock
//   i_rst_n      asynchronous active-low reset (state = card absent)
//   i_cprsnt_n   raw card-present pin, 0 = card present
//   o_present    debounced presence, 1 = card present (registered)
// -----------------------------------------------------------------------------
module cprsnt_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_cprsnt_n,
    output logic o_present
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    r_sync;
    logic          r_present;
    logic [CW-1:0] r_cnt;
    logic          w_sample_present;

    // Pin is active low; sync chain resets to 1 (absent).
    assign w_sample_present = ~r_sync[1];

    // Two-flop synchroniser for the asynchronous pin.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], i_cprsnt_n};
        end
    end

    // The run counter only advances while the sample disagrees with the
    // accepted level, so any sample that agrees restarts the run.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_present <= 1'b0;
            r_cnt     <= {CW{1'b0}};
        end else if (w_sample_present == r_present) begin
            r_present <= r_present;
            r_cnt     <= {CW{1'b0}};
        end else if (r_cnt == DB_LAST) begin
            r_present <= w_sample_present;
            r_cnt     <= {CW{1'b0}};
        end else begin
            r_present <= r_present;
            r_cnt     <= r_cnt + CW'(1);
        end
    end

    assign o_present = r_present;

endmodule

// File: rtl/link_bringup_seq.sv
// -----------------------------------------------------------------------------
// link_bringup_seq
// PCIe endpoint bring-up sequencer: waits for a debounced card, pulses PERST#,
// waits for link-up, runs the configurator, and retries with a PERST#
// back-off on any failure until MAX_RETRIES retries are spent.
// Optional feature: define LINK_BRINGUP_HOTPLUG_EN to return to IDLE on a
// debounced card removal in any non-IDLE state.
// Ports:
//   user_clk         sole clock
//   sys_rst_n_c      asynchronous active-low reset, released synchronously
//   cprsnt           asynchronous card present pin, 0 = present
//   user_lnk_up      PCIe link up (user_clk domain)
//   finished_config  configurator success (level)
//   failed_config    configurator failure (level, wins over success)
//   restart          one-cycle request for a full re-bringup
//   perst_n          endpoint PERST#
//   start_config     configurator start level (high throughout CONFIG)
//   seq_ready        high only in READY
//   seq_failed       high only in FAIL
//   seq_state        current state encoding
//   retry_cnt        retries used so far
// -----------------------------------------------------------------------------
module link_bringup_seq #(
    parameter int DEBOUNCE_CYCLES     = 16,
    parameter int PERST_CYCLES        = 25000000,
    parameter int LINK_TIMEOUT_CYCLES = 250000000,
    parameter int MAX_RETRIES         = 3,
    parameter int CNT_W               = 32
) (
    input  logic                               user_clk,
    input  logic                               sys_rst_n_c,
    input  logic                               cprsnt,
    input  logic                               user_lnk_up,
    input  logic                               finished_config,
    input  logic                               failed_config,
    input  logic                               restart,
    output logic                               perst_n,
    output logic                               start_config,
    output logic                               seq_ready,
    output logic                               seq_failed,
    output logic [2:0]                         seq_state,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt
);

    import link_bringup_pkg::*;

    localparam int RW = $clog2(MAX_RETRIES + 1);
    localparam logic [CNT_W-1:0] PERST_LAST = CNT_W'(PERST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(LINK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [RW-1:0]    RETRY_MAX  = RW'(MAX_RETRIES);

    logic [1:0]       r_rst_sync;
    logic             w_rst_n;
    logic             w_card_present;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [RW-1:0]    r_retry;
    logic             w_fault;
    logic             w_retry_inc;
    logic             w_retry_clr;
    logic             w_cnt_clr;

    logic             r_perst_n;
    logic             r_start_config;
    logic             r_seq_ready;
    logic             r_seq_failed;
    logic             w_perst_n_nxt;
    logic             w_start_nxt;
    logic             w_ready_nxt;
    logic             w_failed_nxt;

    // Reset synchroniser: assertion passes straight through the async clear,
    // release reaches the core only after two clock edges.
    always_ff @(posedge user_clk or negedge sys_rst_n_c) begin
        if (!sys_rst_n_c) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    cprsnt_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_cprsnt_debounce (
        .i_clk      (user_clk),
        .i_rst_n    (w_rst_n),
        .i_cprsnt_n (cprsnt),
        .o_present  (w_card_present)
    );

    // Next-state logic. restart outranks everything; a fault from LINK_WAIT,
    // CONFIG or READY goes to BACKOFF unless the retry budget is spent.
    always_comb begin
        w_state_nxt = r_state;
        w_fault     = 1'b0;
        w_retry_inc = 1'b0;
        w_retry_clr = 1'b0;
        if (restart) begin
            w_state_nxt = ST_IDLE;
            w_retry_clr = 1'b1;
`ifdef LINK_BRINGUP_HOTPLUG_EN
        end else if (!w_card_present && (r_state != ST_IDLE)) begin
            w_state_nxt = ST_IDLE;
            w_retry_clr = 1'b1;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_card_present) begin
                        w_state_nxt = ST_PERST;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_PERST: begin
                    if (r_cnt == PERST_LAST) begin
                        w_state_nxt = ST_LINK_WAIT;
                    end else begin
                        w_state_nxt = ST_PERST;
                    end
                end
                ST_LINK_WAIT: begin
                    if (user_lnk_up) begin
                        w_state_nxt = ST_CONFIG;
                    end else if (r_cnt == TMO_LAST) begin
                        w_fault = 1'b1;
                    end else begin
                        w_state_nxt = ST_LINK_WAIT;
                    end
                end
                ST_CONFIG: begin
                    // Link was up on entry, so a low level here is a drop.
                    if (failed_config || !user_lnk_up || (r_cnt == TMO_LAST)) begin
                        w_fault = 1'b1;
                    end else if (finished_config) begin
                        w_state_nxt = ST_READY;
                    end else begin
                        w_state_nxt = ST_CONFIG;
                    end
                end
                ST_READY: begin
                    if (!user_lnk_up) begin
                        w_fault = 1'b1;
                    end else begin
                        w_state_nxt = ST_READY;
                    end
                end
                ST_BACKOFF: begin
                    if (r_cnt == PERST_LAST) begin
                        w_state_nxt = ST_PERST;
                    end else begin
                        w_state_nxt = ST_BACKOFF;
                    end
                end
                ST_FAIL: begin
                    w_state_nxt = ST_FAIL;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
            if (w_fault) begin
                if (r_retry == RETRY_MAX) begin
                    w_state_nxt = ST_FAIL;
                end else begin
                    w_state_nxt = ST_BACKOFF;
                    w_retry_inc = 1'b1;
                end
            end else begin
                w_retry_inc = 1'b0;
            end
        end
    end

    // The shared counter restarts on every state change and on restart.
    assign w_cnt_clr = restart | (w_state_nxt != r_state);

    // Outputs are decoded from the next state so the registered values line
    // up with the state they belong to.
    always_comb begin
        w_perst_n_nxt = ~perst_asserted(w_state_nxt);
        w_start_nxt   = (w_state_nxt == ST_CONFIG);
        w_ready_nxt   = (w_state_nxt == ST_READY);
        w_failed_nxt  = (w_state_nxt == ST_FAIL);
    end

    // State, saturating counter, retry count and registered outputs.
    always_ff @(posedge user_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state        <= ST_IDLE;
            r_cnt          <= {CNT_W{1'b0}};
            r_retry        <= {RW{1'b0}};
            r_perst_n      <= 1'b0;
            r_start_config <= 1'b0;
            r_seq_ready    <= 1'b0;
            r_seq_failed   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_cnt_clr) begin
                r_cnt <= {CNT_W{1'b0}};
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_cnt <= r_cnt;
            end
            if (w_retry_clr) begin
                r_retry <= {RW{1'b0}};
            end else if (w_retry_inc) begin
                r_retry <= r_retry + RW'(1);
            end else begin
                r_retry <= r_retry;
            end
            r_perst_n      <= w_perst_n_nxt;
            r_start_config <= w_start_nxt;
            r_seq_ready    <= w_ready_nxt;
            r_seq_failed   <= w_failed_nxt;
        end
    end

    assign perst_n      = r_perst_n;
    assign start_config = r_start_config;
    assign seq_ready    = r_seq_ready;
    assign seq_failed   = r_seq_failed;
    assign seq_state    = r_state;
    assign retry_cnt    = r_retry;

endmodule
